// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the five-stage pipeline control blocks: FSM encoding,
// register-address width, flush NOP constant and a source-match helper.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_REFILL = 2'b01,
    ST_REPLAY = 2'b10
  } hz_state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0) loaded by flushed stage registers.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic src_match(input logic                  uses,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rd);
    return uses & (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose non-x0 destination is
// read by the instruction in ID.
module load_use_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);
  import riscv_pipe_pkg::*;

  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    (src_match(id_uses_rs1, id_rs1, ex_rd) |
                     src_match(id_uses_rs2, id_rs2, ex_rd));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch squashes and a
// dcache-miss refill sequence, with saturating stall/miss counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dcache_hit,
  input  logic             refill_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             refill_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  import riscv_pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             load_use;
  logic             miss;
  logic             miss_event;

  load_use_detect u_lud (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  assign miss = mem_access & ~dcache_hit;

  // Next-state and enable/flush decode; reset overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    refill_req  = 1'b0;
    miss_event  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (miss) begin
          state_d    = ST_REFILL;
          miss_event = 1'b1;
        end else if (ex_branch_taken) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
          id_ex_flush = 1'b1;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        end
      end
      ST_REFILL: begin
        refill_req = 1'b1;
        if (refill_ack) begin
          state_d = ST_REPLAY;
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_REPLAY: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      refill_req  = 1'b0;
      miss_event  = 1'b0;
      state_d     = ST_RUN;
    end else begin
      state_d = state_d;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    miss_d  = miss_q;
    if (!pc_en && !(&stall_q)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (miss_event && !(&miss_q)) begin
      miss_d = miss_q + CNT_ONE;
    end else begin
      miss_d = miss_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      miss_q  <= miss_d;
    end
  end

  assign stall_cnt = stall_q;
  assign miss_cnt  = miss_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. Each cycle it generates the per-register write enables (the `hit`-style enable on the IF/ID, ID/EX, EX/MEM and MEM/WB registers) and the bubble/flush controls. Its decisions come from three sources: load-use hazards, taken branches resolved in EX, and data-cache misses in MEM. Cache misses are sequenced through a refill handshake with the memory side, and the block keeps saturating stall/miss performance counters.

## Interface
Parameters:
- `CNT_W`, 16, width of each performance counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `id_rs1`, `id_rs2`  in  5  source register numbers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1  each 1 when the matching source is actually read.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_branch_taken`  in  1  branch/jump in EX resolved taken.
- `mem_access`  in  1  instruction in MEM is a load/store.
- `dcache_hit`  in  1  data-cache hit; meaningful only when `mem_access`=1.
- `refill_ack`  in  1  memory-side refill complete (single-cycle pulse).
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1  register update enables.
- `if_id_flush`, `id_ex_flush`  out  1  load a NOP/zero control field instead of the incoming data.
- `refill_req`  out  1  refill request, held high until acknowledged.
- `stall_cnt`, `miss_cnt`  out  `CNT_W`  performance counters.

## Operation
- FSM states: RUN, REFILL, REPLAY.
- RUN, priority order. Outputs are combinational from state and inputs.
  1. **Miss** (`mem_access & ~dcache_hit`):
     - All five enables 0; no flush.
     - Next state REFILL.
     - `miss_cnt` +1.
  2. **Branch** (`ex_branch_taken`, no miss):
     - All enables 1.
     - `if_id_flush`=1 and `id_ex_flush`=1, squashing the two younger instructions.
  3. **Load-use**:
     - Condition: `ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`, with no miss and no branch.
     - `pc_en`=0, `if_id_en`=0.
     - `id_ex_en`=1 with `id_ex_flush`=1, inserting a bubble.
     - `ex_mem_en`=`mem_wb_en`=1.
  4. **Otherwise**: all enables 1, no flush.
- REFILL:
  - All enables 0; `refill_req`=1.
  - On `refill_ack`=1, next state REPLAY; otherwise stay.
- REPLAY:
  - All enables 0; `refill_req`=0.
  - One cycle for the cache to present the refilled line, then RUN.
- `stall_cnt` +1 in every cycle with `pc_en`=0 (reset cycles excluded).
- Both counters saturate at all-ones; no wrap.
- Miss + branch in the same cycle: the miss wins. Because EX/MEM is frozen, `ex_branch_taken` is still asserted on the return to RUN, and the flush happens then.
- Miss + load-use in the same cycle: the miss wins. The load-use condition is re-evaluated in RUN after the replay.
- `refill_ack` outside REFILL is ignored.
- A miss re-detected in the first RUN cycle after REPLAY starts a new refill and counts as a new miss.

## Timing
- Enable/flush outputs have zero-cycle latency (combinational) in RUN. In REFILL and REPLAY they are a function of state only.
- `refill_req` rises in the cycle after miss detection and falls in the cycle after `refill_ack` is sampled.
- Minimum miss penalty: 1 detect + N REFILL (N ≥ 1) + 1 REPLAY cycles of full-pipeline freeze.
- Load-use costs exactly 1 bubble. A taken branch costs exactly 2 squashed slots.
- Reset:
  - While `rst`=1, outputs are forced: all enables 0, `if_id_flush`=`id_ex_flush`=1, `refill_req`=0.
  - Next state RUN; `stall_cnt`=`miss_cnt`=0.
  - `rst` asserted mid-REFILL abandons the refill; `refill_req` is 0 in the reset cycle itself.

## Structure
- Shared package `riscv_pipe_pkg`:
  - State encoding: RUN=2'b00, REFILL=2'b01, REPLAY=2'b10; 2'b11 is illegal and recovers to RUN.
  - `REG_ADDR_W`=5.
  - NOP control-field constant used by flush consumers.
- One sub-module: `load_use_detect`, a purely combinational comparator producing the load-use hazard flag.
- Top level holds the FSM, the output decode and the two counters.

## Test plan
- **Load-use**:
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1.
  - Response: `pc_en`=`if_id_en`=0, `id_ex_flush`=1, `ex_mem_en`=1, `stall_cnt` 0→1.
  - Repeating the stimulus with `ex_rd`=0 → no stall.
- **Branch**: `ex_branch_taken`=1 alone → all enables 1, both flushes 1, `stall_cnt` unchanged.
- **Miss with 3-cycle ack**:
  - Stimulus: `mem_access`=1, `dcache_hit`=0; `refill_ack` pulsed 3 cycles after `refill_req` rises.
  - Response: `refill_req` high exactly 3 cycles, then 1 REPLAY cycle, then RUN; `miss_cnt`=1, `stall_cnt`=5.
- **Miss + branch simultaneously**: freeze first; after REPLAY, with `dcache_hit`=1 and `ex_branch_taken` still 1 → flush both in the first RUN cycle.
- **Reset mid-REFILL**: `rst`=1 for one cycle during REFILL → `refill_req`=0 that cycle, state RUN, counters 0, and a stray `refill_ack` next cycle is ignored.
- **Saturation**: `CNT_W`=4, 20 consecutive load-use stalls → `stall_cnt` holds at 15.
